// File: rtl/timer_reg_bank.sv
// Register bank for a multi-channel timer: shadow/active duty and target,
// per-channel control with sticky lock, command pulses and W1C interrupts.
module timer_reg_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 10,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      acc_en_i,
  input  logic                      wr_en_i,
  input  logic [CH_W+2:0]           addr_i,
  input  logic [15:0]               wdata_i,
  input  logic [NUM_CH*CNT_W-1:0]   act_cnt_i,
  input  logic [NUM_CH*CNT_W-1:0]   capt_val_i,
  input  logic [NUM_CH-1:0]         capt_evt_i,
  input  logic [NUM_CH-1:0]         ovf_evt_i,
  input  logic [NUM_CH-1:0]         upd_i,
  output logic [15:0]               rdata_o,
  output logic                      rvalid_o,
  output logic [NUM_CH-1:0]         en_o,
  output logic [2*NUM_CH-1:0]       mode_o,
  output logic [NUM_CH*CNT_W-1:0]   duty_o,
  output logic [NUM_CH*CNT_W-1:0]   target_o,
  output logic [NUM_CH-1:0]         clear_o,
  output logic [NUM_CH-1:0]         sw_trig_o,
  output logic                      irq_o
);

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DUTY = 3'd1;
  localparam logic [2:0] REG_TGT  = 3'd2;
  localparam logic [2:0] REG_ACT  = 3'd3;
  localparam logic [2:0] REG_CAPT = 3'd4;
  localparam logic [2:0] REG_CMD  = 3'd5;
  localparam logic [2:0] REG_STAT = 3'd6;
  localparam logic [2:0] REG_IEN  = 3'd7;

  // Bus: one access per cycle with acc_en_i high, never stalled. A read
  // (wr_en_i=0) returns rdata_o with rvalid_o=1 exactly one cycle later;
  // in every other cycle rdata_o and rvalid_o are 0.
  logic [CH_W-1:0] ch;
  logic [2:0]      rsel;
  logic            ch_ok;
  logic            rd_acc;

  assign ch     = addr_i[CH_W+2:3];
  assign rsel   = addr_i[2:0];
  assign ch_ok  = ({1'b0, ch} < (CH_W+1)'(NUM_CH));
  assign rd_acc = acc_en_i & ~wr_en_i;

  logic [NUM_CH-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = acc_en_i & wr_en_i & ch_ok & (ch == CH_W'(c));
    end
  end

  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh_q, duty_sh_d, tgt_sh_q, tgt_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d, tgt_act_q, tgt_act_d;
  logic [NUM_CH-1:0]            en_q, en_d, lock_q, lock_d;
  logic [NUM_CH-1:0]            clear_q, clear_d, trig_q, trig_d;
  logic [NUM_CH-1:0][1:0]       mode_q, mode_d, stat_q, stat_d, ien_q, ien_d;
  logic [15:0]                  rdata_q, rdata_d;
  logic                         rvalid_q;
  logic                         irq_q, irq_d;

  always_comb begin
    duty_sh_d  = duty_sh_q;
    tgt_sh_d   = tgt_sh_q;
    duty_act_d = duty_act_q;
    tgt_act_d  = tgt_act_q;
    en_d       = en_q;
    lock_d     = lock_q;
    mode_d     = mode_q;
    ien_d      = ien_q;
    stat_d     = stat_q;
    clear_d    = '0;
    trig_d     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit[c] && !lock_q[c]) begin
        if (rsel == REG_CTRL) begin
          lock_d[c] = wdata_i[15];
          mode_d[c] = wdata_i[5:4];
          en_d[c]   = wdata_i[0];
        end
        if (rsel == REG_DUTY) duty_sh_d[c] = wdata_i[CNT_W-1:0];
        if (rsel == REG_TGT)  tgt_sh_d[c]  = wdata_i[CNT_W-1:0];
      end
      if (wr_hit[c] && rsel == REG_CMD) begin
        clear_d[c] = wdata_i[0];
        trig_d[c]  = wdata_i[4];
      end
      // Copy from the next shadow value so a same-cycle shadow write is taken.
      if (upd_i[c] || (wr_hit[c] && rsel == REG_CMD && wdata_i[8])) begin
        duty_act_d[c] = duty_sh_d[c];
        tgt_act_d[c]  = tgt_sh_d[c];
      end
      if (wr_hit[c] && rsel == REG_IEN) ien_d[c] = wdata_i[1:0];
      // Event set wins over a simultaneous write-1-to-clear.
      stat_d[c] = (stat_q[c] & ~((wr_hit[c] && rsel == REG_STAT) ? wdata_i[1:0] : 2'b00))
                | {capt_evt_i[c], ovf_evt_i[c]};
    end
    irq_d = |(stat_q & ien_q);
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc && ch_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch == CH_W'(c)) begin
          case (rsel)
            REG_CTRL: rdata_d = {lock_q[c], 9'b0, mode_q[c], 3'b0, en_q[c]};
            REG_DUTY: rdata_d = 16'(duty_sh_q[c]);
            REG_TGT:  rdata_d = 16'(tgt_sh_q[c]);
            REG_ACT:  rdata_d = 16'(act_cnt_i[c*CNT_W +: CNT_W]);
            REG_CAPT: rdata_d = 16'(capt_val_i[c*CNT_W +: CNT_W]);
            REG_STAT: rdata_d = {14'b0, stat_q[c]};
            REG_IEN:  rdata_d = {14'b0, ien_q[c]};
            default:  rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      duty_sh_q  <= '0;
      tgt_sh_q   <= '0;
      duty_act_q <= '0;
      tgt_act_q  <= '0;
      en_q       <= '0;
      lock_q     <= '0;
      mode_q     <= '0;
      ien_q      <= '0;
      stat_q     <= '0;
      clear_q    <= '0;
      trig_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      tgt_sh_q   <= tgt_sh_d;
      duty_act_q <= duty_act_d;
      tgt_act_q  <= tgt_act_d;
      en_q       <= en_d;
      lock_q     <= lock_d;
      mode_q     <= mode_d;
      ien_q      <= ien_d;
      stat_q     <= stat_d;
      clear_q    <= clear_d;
      trig_q     <= trig_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rd_acc;
      irq_q      <= irq_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign en_o      = en_q;
  assign mode_o    = mode_q;
  assign duty_o    = duty_act_q;
  assign target_o  = tgt_act_q;
  assign clear_o   = clear_q;
  assign sw_trig_o = trig_q;
  assign irq_o     = irq_q;

  // Only some write-data bits carry meaning; the rest are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

endmodule

// File: tb/tb_timer_reg_bank.sv
// Directed bench for timer_reg_bank: register-map vector table plus
// hand-written sequences for shadow update, lock, W1C/irq, commands and reset.
module tb_timer_reg_bank;

  localparam int NC  = 4;
  localparam int CW  = 10;
  localparam int NC2 = 5;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rstn_i;
  always #5 clk_i = ~clk_i;

  logic              acc_en_i, wr_en_i;
  logic [4:0]        addr_i;
  logic [15:0]       wdata_i;
  logic [NC*CW-1:0]  act_cnt_i, capt_val_i;
  logic [NC-1:0]     capt_evt_i, ovf_evt_i, upd_i;
  logic [15:0]       rdata_o;
  logic              rvalid_o;
  logic [NC-1:0]     en_o;
  logic [2*NC-1:0]   mode_o;
  logic [NC*CW-1:0]  duty_o, target_o;
  logic [NC-1:0]     clear_o, sw_trig_o;
  logic              irq_o;

  logic [5:0]        addr2;
  logic [NC2*CW-1:0] act2, capt2;
  logic [NC2-1:0]    evt2;
  logic [15:0]       rdata2;
  logic              rvalid2;
  logic [NC2-1:0]    en2, clear2, trig2;
  logic [2*NC2-1:0]  mode2;
  logic [NC2*CW-1:0] duty2, tgt2;
  logic              irq2;

  timer_reg_bank #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .acc_en_i(acc_en_i), .wr_en_i(wr_en_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .act_cnt_i(act_cnt_i), .capt_val_i(capt_val_i),
    .capt_evt_i(capt_evt_i), .ovf_evt_i(ovf_evt_i), .upd_i(upd_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .en_o(en_o), .mode_o(mode_o),
    .duty_o(duty_o), .target_o(target_o), .clear_o(clear_o), .sw_trig_o(sw_trig_o),
    .irq_o(irq_o)
  );

  // Five-channel instance so that channel field 5 is out of range.
  timer_reg_bank #(.NUM_CH(NC2), .CNT_W(CW)) dut2 (
    .clk_i(clk_i), .rstn_i(rstn_i), .acc_en_i(acc_en_i), .wr_en_i(wr_en_i),
    .addr_i(addr2), .wdata_i(wdata_i), .act_cnt_i(act2), .capt_val_i(capt2),
    .capt_evt_i(evt2), .ovf_evt_i(evt2), .upd_i(evt2),
    .rdata_o(rdata2), .rvalid_o(rvalid2), .en_o(en2), .mode_o(mode2),
    .duty_o(duty2), .target_o(tgt2), .clear_o(clear2), .sw_trig_o(trig2),
    .irq_o(irq2)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Driver: one bus access, then the bus idles.
  task automatic bus(input logic wr, input logic [4:0] a, input logic [15:0] d);
    acc_en_i = 1'b1;
    wr_en_i  = wr;
    addr_i   = a;
    wdata_i  = d;
    step();
    acc_en_i = 1'b0;
    wr_en_i  = 1'b0;
  endtask

  function automatic logic [4:0] a1(input int ch, input int r);
    return 5'((ch << 3) | r);
  endfunction

  function automatic logic [5:0] a2(input int ch, input int r);
    return 6'((ch << 3) | r);
  endfunction

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        exp_valid;
    logic [15:0] exp_data;
    string       name;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1'b0, a1(0, 0), 16'h0000, 1'b1, 16'h0000, "rd_ctrl0_rst"};
    vt[1]  = '{1'b1, a1(0, 1), 16'h1234, 1'b0, 16'h0000, "wr_duty0"};
    vt[2]  = '{1'b0, a1(0, 1), 16'h0000, 1'b1, 16'h0234, "rd_duty0_trunc"};
    vt[3]  = '{1'b1, a1(1, 2), 16'hFFFF, 1'b0, 16'h0000, "wr_tgt1"};
    vt[4]  = '{1'b0, a1(1, 2), 16'h0000, 1'b1, 16'h03FF, "rd_tgt1_trunc"};
    vt[5]  = '{1'b1, a1(2, 7), 16'hFFFF, 1'b0, 16'h0000, "wr_ien2"};
    vt[6]  = '{1'b0, a1(2, 7), 16'h0000, 1'b1, 16'h0003, "rd_ien2"};
    vt[7]  = '{1'b1, a1(3, 0), 16'h0031, 1'b0, 16'h0000, "wr_ctrl3"};
    vt[8]  = '{1'b0, a1(3, 0), 16'h0000, 1'b1, 16'h0031, "rd_ctrl3"};
    vt[9]  = '{1'b0, a1(3, 5), 16'h0000, 1'b1, 16'h0000, "rd_cmd3_zero"};
    vt[10] = '{1'b0, a1(1, 3), 16'h0000, 1'b1, 16'h02AA, "rd_act1"};
    vt[11] = '{1'b0, a1(2, 4), 16'h0000, 1'b1, 16'h0111, "rd_capt2"};
    vt[12] = '{1'b1, a1(2, 7), 16'h0000, 1'b0, 16'h0000, "wr_ien2_off"};
    vt[13] = '{1'b0, a1(2, 7), 16'h0000, 1'b1, 16'h0000, "rd_ien2_off"};
    vt[14] = '{1'b0, a1(0, 6), 16'h0000, 1'b1, 16'h0000, "rd_stat0"};
    vt[15] = '{1'b0, a1(0, 2), 16'h0000, 1'b1, 16'h0000, "rd_tgt0"};

    rstn_i     = 1'b0;
    acc_en_i   = 1'b0;
    wr_en_i    = 1'b0;
    addr_i     = '0;
    wdata_i    = '0;
    act_cnt_i  = {10'h001, 10'h3C3, 10'h2AA, 10'h155};
    capt_val_i = {10'h000, 10'h111, 10'h000, 10'h000};
    capt_evt_i = '0;
    ovf_evt_i  = '0;
    upd_i      = '0;
    addr2      = a2(7, 0);
    act2       = {40'h0, 10'h155};
    capt2      = '0;
    evt2       = '0;

    // Reset state
    repeat (3) step();
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_rdata", rdata_o, 16'h0);
    check("rst_en_mode", {en_o, mode_o}, 12'h0);
    check("rst_duty_tgt", {duty_o, target_o}, 80'h0);
    check("rst_pulses_irq", {clear_o, sw_trig_o, irq_o}, 9'h0);
    rstn_i = 1'b1;
    step();

    // Register-map vector table
    for (int i = 0; i < 16; i++) begin
      bus(vt[i].wr, vt[i].addr, vt[i].wdata);
      check({vt[i].name, "_rvalid"}, rvalid_o, vt[i].exp_valid);
      check({vt[i].name, "_rdata"}, rdata_o, vt[i].exp_data);
    end
    check("tbl_en", en_o, 4'b1000);
    check("tbl_mode", mode_o, 8'hC0);
    check("tbl_duty_no_upd", duty_o, 40'h0);
    check("tbl_tgt_no_upd", target_o, 40'h0);

    // Shadow duty held until the period-boundary pulse
    bus(1'b1, a1(2, 1), 16'h03FF);
    check("duty_pre_upd_a", duty_o, 40'h0);
    step();
    step();
    check("duty_pre_upd_b", duty_o, 40'h0);
    upd_i = 4'b0100;
    step();
    upd_i = 4'b0000;
    check("duty_upd2", duty_o, {10'h000, 10'h3FF, 10'h000, 10'h000});
    upd_i = 4'b0010;
    bus(1'b1, a1(1, 1), 16'h00AB);
    upd_i = 4'b0000;
    check("duty_same_cycle_upd1", duty_o, {10'h000, 10'h3FF, 10'h0AB, 10'h000});
    check("tgt_upd1", target_o, {10'h000, 10'h000, 10'h3FF, 10'h000});

    // Lock
    bus(1'b1, a1(1, 0), 16'h8011);
    bus(1'b1, a1(1, 0), 16'h0000);
    bus(1'b1, a1(1, 1), 16'h0055);
    bus(1'b0, a1(1, 0), 16'h0000);
    check("lock_ctrl_rd", rdata_o, 16'h8011);
    bus(1'b0, a1(1, 1), 16'h0000);
    check("lock_duty_rd", rdata_o, 16'h00AB);
    check("lock_en", en_o, 4'b1010);
    check("lock_mode", mode_o, 8'hC4);

    // Interrupt status / enable
    bus(1'b1, a1(0, 7), 16'h0001);
    ovf_evt_i = 4'b0001;
    step();
    ovf_evt_i = 4'b0000;
    step();
    check("irq_ovf_set", irq_o, 1'b1);
    ovf_evt_i = 4'b0001;
    bus(1'b1, a1(0, 6), 16'h0001);
    ovf_evt_i = 4'b0000;
    check("irq_w1c_race_a", irq_o, 1'b1);
    bus(1'b0, a1(0, 6), 16'h0000);
    check("stat_w1c_race", rdata_o, 16'h0001);
    check("irq_w1c_race_b", irq_o, 1'b1);
    bus(1'b1, a1(0, 6), 16'h0001);
    step();
    check("irq_cleared", irq_o, 1'b0);
    bus(1'b0, a1(0, 6), 16'h0000);
    check("stat_cleared", rdata_o, 16'h0000);
    capt_evt_i = 4'b0001;
    step();
    capt_evt_i = 4'b0000;
    step();
    step();
    check("irq_capt_masked", irq_o, 1'b0);
    bus(1'b0, a1(0, 6), 16'h0000);
    check("stat_capt", rdata_o, 16'h0002);

    // Commands
    bus(1'b1, a1(3, 2), 16'h02C5);
    bus(1'b1, a1(3, 1), 16'h01A1);
    bus(1'b1, a1(3, 5), 16'h0111);
    check("cmd_clear", clear_o, 4'b1000);
    check("cmd_trig", sw_trig_o, 4'b1000);
    check("cmd_force_duty", duty_o, {10'h1A1, 10'h3FF, 10'h0AB, 10'h000});
    check("cmd_force_tgt", target_o, {10'h2C5, 10'h000, 10'h3FF, 10'h000});
    step();
    check("cmd_pulse_end", {clear_o, sw_trig_o}, 8'h00);
    bus(1'b1, a1(3, 5), 16'h0001);
    check("cmd_clear_only", {clear_o, sw_trig_o}, 8'h80);
    step();
    check("cmd_clear_only_end", {clear_o, sw_trig_o}, 8'h00);

    // Back-to-back reads, including an out-of-range channel on dut2
    acc_en_i = 1'b1;
    wr_en_i  = 1'b0;
    addr_i   = a1(0, 3);
    addr2    = a2(0, 3);
    step();
    check("b2b_rd1", {rvalid_o, rdata_o}, 17'h1_0155);
    check("b2b_rd1_ch5dut", {rvalid2, rdata2}, 17'h1_0155);
    addr_i = a1(1, 3);
    addr2  = a2(5, 3);
    step();
    acc_en_i = 1'b0;
    check("b2b_rd2", {rvalid_o, rdata_o}, 17'h1_02AA);
    check("b2b_rd_ch5", {rvalid2, rdata2}, 17'h1_0000);
    step();
    check("b2b_idle", {rvalid_o, rvalid2}, 2'b00);
    addr_i = a1(0, 7);
    addr2  = a2(5, 0);
    bus(1'b1, a1(0, 7), 16'h0001);
    check("ch5_wr_ignored", en2, 5'b00000);
    addr2 = a2(7, 0);

    // Reset in the middle of a read
    bus(1'b0, a1(1, 0), 16'h0000);
    check("pre_rst_rd", {rvalid_o, rdata_o}, 17'h1_8011);
    #2;
    rstn_i = 1'b0;
    #1;
    check("rst_async_rd", {rvalid_o, rdata_o}, 17'h0);
    check("rst_async_ctl", {en_o, duty_o, irq_o}, 45'h0);
    step();
    step();
    rstn_i = 1'b1;
    step();
    check("rst_release_rd", {rvalid_o, rdata_o}, 17'h0);
    check("rst_release_pulse", {clear_o, sw_trig_o}, 8'h00);
    bus(1'b0, a1(1, 0), 16'h0000);
    check("rst_lock_cleared", {rvalid_o, rdata_o}, 17'h1_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_reg_bank.md
TIMER_REG_BANK -- requirements
Module: timer_reg_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of timer channels, legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 10: counter/duty/target width, legal 4..16.
REQ-003 SHALL derive CH_W = max(1, clog2(NUM_CH)); addr_i width = CH_W+3.
REQ-004 SHALL use clock clk_i: rising-edge clock for all state.
REQ-005 SHALL use reset rstn_i: asynchronous, active-low.
REQ-006 SHALL have port acc_en_i  in  1  bus access strobe, one cycle per access.
REQ-007 SHALL have port wr_en_i  in  1  1=write, 0=read.
REQ-008 SHALL have port addr_i  in  CH_W+3  [CH_W+2:3]=channel, [2:0]=register.
REQ-009 SHALL have port wdata_i  in  16  write data.
REQ-010 SHALL have port act_cnt_i  in  NUM_CH*CNT_W  live counter value per channel.
REQ-011 SHALL have port capt_val_i  in  NUM_CH*CNT_W  captured value per channel.
REQ-012 SHALL have ports capt_evt_i / ovf_evt_i / upd_i  in  NUM_CH each  one-cycle capture, overflow and period-boundary pulses.
REQ-013 SHALL have port rdata_o  out  16  registered read data.
REQ-014 SHALL have port rvalid_o  out  1  read data valid.
REQ-015 SHALL have ports en_o  out  NUM_CH  and  mode_o  out  2*NUM_CH  active control.
REQ-016 SHALL have ports duty_o / target_o  out  NUM_CH*CNT_W each  active (not shadow) values.
REQ-017 SHALL have ports clear_o / sw_trig_o  out  NUM_CH each  registered command pulses.
REQ-018 SHALL have port irq_o  out  1  registered interrupt.

Function
REQ-019 SHALL decode per-channel register map: 0 CTRL{lock[15], mode[5:4], en[0]}, 1 DUTY shadow, 2 TARGET shadow, 3 ACT_CNT (RO), 4 CAPT (RO), 5 CMD (WO: clear[0], sw_trig[4], force_upd[8]), 6 IRQ_STAT (W1C: ovf[0], capt[1]), 7 IRQ_EN{capt[1], ovf[0]}.
REQ-020 SHALL ignore accesses whose channel field is >= NUM_CH: no write effect, read returns 0 with rvalid_o=1.
REQ-021 SHALL write DUTY/TARGET into shadow registers only, truncating wdata_i to CNT_W bits; read back returns shadow, zero-extended to 16.
REQ-022 SHALL copy shadow to active duty/target on the cycle after upd_i[ch]=1 or a CMD write with force_upd=1; a same-cycle shadow write is included in that copy.
REQ-023 SHALL ignore CTRL, DUTY, TARGET writes to a channel while its lock=1; lock is set by writing 1 and cleared only by reset.
REQ-024 SHALL drive clear_o[ch]/sw_trig_o[ch] high for exactly one cycle, one cycle after the CMD write; CMD reads return 0.
REQ-025 SHALL set IRQ_STAT bits on ovf_evt_i/capt_evt_i regardless of IRQ_EN; W1C clears written-1 bits; a simultaneous set and clear leaves the bit set.
REQ-026 SHALL assert irq_o one cycle after any channel has (IRQ_STAT & IRQ_EN) != 0, deasserting one cycle after none has.
REQ-027 SHALL return read data on rdata_o with rvalid_o=1 exactly one cycle after acc_en_i=1, wr_en_i=0; otherwise rdata_o=0, rvalid_o=0.
REQ-028 SHALL accept back-to-back accesses every cycle with no stall.

Reset
REQ-029 SHALL on rstn_i=0 clear all shadow, active, CTRL, lock, IRQ_STAT, IRQ_EN to 0 and drive every output to 0 asynchronously.
REQ-030 SHALL discard an access or pending command/read on the cycle reset asserts; no pulse or rvalid_o after release.

Verification
REQ-031 SHALL verify NUM_CH=4, CNT_W=10: write DUTY ch2 = 0x3FF -> duty_o ch2 stays 0 until upd_i[2] pulse, then 0x3FF next cycle; other channels 0.
REQ-032 SHALL verify CTRL ch1 write 0x8011 (lock, mode=1, en) then write 0x0000 -> en_o[1]=1, mode ch1=1 retained; readback 0x8011.
REQ-033 SHALL verify IRQ_EN ch0=0x1, ovf_evt_i[0] pulse -> irq_o=1 one cycle later; W1C 0x1 concurrent with another ovf pulse -> bit stays 1, irq_o stays 1.
REQ-034 SHALL verify CMD ch3 write 0x0111 -> clear_o[3], sw_trig_o[3] single-cycle pulses next cycle and active=shadow for ch3.
REQ-035 SHALL verify back-to-back reads ACT_CNT ch0 (act_cnt_i=0x155) then channel 5 -> rdata_o 0x0155 then 0x0000, rvalid_o high both cycles.
REQ-036 SHALL verify reset asserted mid-read -> rdata_o=0, rvalid_o=0 immediately and after release.
